adder_sum_accumulator: RTL and testbench

Downstream consumer of the adder stage: captures each valid sum (`c` qualified by `valid`), accumulates FRAME_LEN consecutive valid sums into a saturating accumulator, and presents each completed frame total on a single-entry valid/ready output register. The adder has no backpressure, so accumulation never stalls. A completed frame that cannot be handed off is dropped and counted.

---
 rtl/adder_sum_accumulator_if.sv | 25 ++
 rtl/adder_sum_accumulator.sv | 102 ++++++++++
 tb/tb_adder_sum_accumulator.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_sum_accumulator_if.sv
// Bus between the adder stage, the frame accumulator and the frame consumer.
// The master side drives the adder sum and consumer ready; the slave side is the accumulator.
interface adder_sum_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 12
);
    logic [IN_W-1:0]  c;
    logic             valid;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       frame_drops;
    logic             busy;

    modport master (
        output c, valid, out_ready,
        input  out_sum, out_ovf, out_valid, frame_drops, busy
    );

    modport slave (
        input  c, valid, out_ready,
        output out_sum, out_ovf, out_valid, frame_drops, busy
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Sums FRAME_LEN valid adder outputs into a saturating total and offers each total on a
// single-entry valid/ready register; frames arriving while that register is stalled are dropped.
module adder_sum_accumulator #(
    parameter int IN_W      = 5,
    parameter int ACC_W     = 12,
    parameter int FRAME_LEN = 4
) (
    input logic                    clk,
    input logic                    rst,
    adder_sum_accumulator_if.slave bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic [7:0]       drops_q, drops_d;
    logic             busy_q, busy_d;

    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] nxt;
    logic             step_ovf;
    logic             frame_done;
    logic             out_free;

    // One spare bit catches the carry that marks saturation.
    assign sum_wide   = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.c};
    assign step_ovf   = sum_wide[ACC_W];
    assign nxt        = step_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign frame_done = bus.valid && (cnt_q == 8'(FRAME_LEN - 1));
    assign out_free   = (state_q == ST_EMPTY) || bus.out_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        drops_d   = drops_q;

        if (frame_done) begin
            acc_d     = '0;
            acc_ovf_d = 1'b0;
            cnt_d     = 8'd0;
            if (out_free) begin
                out_sum_d = nxt;
                out_ovf_d = acc_ovf_q | step_ovf;
            end else if (drops_q != 8'hFF) begin
                drops_d = drops_q + 8'd1;
            end
        end else if (bus.valid) begin
            acc_d     = nxt;
            acc_ovf_d = acc_ovf_q | step_ovf;
            cnt_d     = cnt_q + 8'd1;
        end

        case (state_q)
            ST_EMPTY: if (frame_done) state_d = ST_FULL;
            ST_FULL:  if (bus.out_ready && !frame_done) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        busy_d = (cnt_d != 8'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            cnt_q     <= 8'd0;
            state_q   <= ST_EMPTY;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
            drops_q   <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
            drops_q   <= drops_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.out_sum     = out_sum_q;
    assign bus.out_ovf     = out_ovf_q;
    assign bus.out_valid   = (state_q == ST_FULL);
    assign bus.frame_drops = drops_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: a 12-bit and a 6-bit accumulator share one stimulus stream
// and are compared against a queue-based frame model plus the directed scenarios.
module tb_adder_sum_accumulator;

    localparam int FRAME_LEN = 4;
    localparam int MAX_A     = 4095;
    localparam int MAX_B     = 63;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    adder_sum_accumulator_if #(.IN_W(5), .ACC_W(12)) bus_a ();
    adder_sum_accumulator_if #(.IN_W(5), .ACC_W(6))  bus_b ();

    adder_sum_accumulator #(.IN_W(5), .ACC_W(12), .FRAME_LEN(FRAME_LEN)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    adder_sum_accumulator #(.IN_W(5), .ACC_W(6), .FRAME_LEN(FRAME_LEN)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: samples of the open frame, and what the output register should hold.
    int   m_q[$];
    logic m_ov;
    int   m_sum_a, m_sum_b;
    logic m_ovf_a, m_ovf_b;
    int   m_drops;
    logic m_busy;

    task automatic model_clear();
        m_q.delete();
        m_ov    = 1'b0;
        m_sum_a = 0;
        m_sum_b = 0;
        m_ovf_a = 1'b0;
        m_ovf_b = 1'b0;
        m_drops = 0;
        m_busy  = 1'b0;
    endtask

    task automatic model_step(input logic v, input int cv, input logic rdy);
        bit done  = 1'b0;
        int total = 0;
        if (v) begin
            m_q.push_back(cv);
            if (m_q.size() == FRAME_LEN) begin
                foreach (m_q[i]) total += m_q[i];
                m_q.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_ov || rdy) begin
                m_ov    = 1'b1;
                m_sum_a = (total > MAX_A) ? MAX_A : total;
                m_ovf_a = (total > MAX_A);
                m_sum_b = (total > MAX_B) ? MAX_B : total;
                m_ovf_b = (total > MAX_B);
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end else if (m_ov && rdy) begin
            m_ov = 1'b0;
        end
        m_busy = (m_q.size() != 0);
    endtask

    // Applies one cycle of stimulus to both DUTs and returns #1 after the rising edge.
    task automatic drive(input logic v, input logic [4:0] cv, input logic rdy);
        bus_a.valid = v;  bus_a.c = cv;  bus_a.out_ready = rdy;
        bus_b.valid = v;  bus_b.c = cv;  bus_b.out_ready = rdy;
        model_step(v, int'(cv), rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 5;
        if (bus_a.out_sum !== 12'd0)    begin n_fails++; $display("FAIL reset_sum: got %0d expected 0", bus_a.out_sum); end
        if (bus_a.out_ovf !== 1'b0)     begin n_fails++; $display("FAIL reset_ovf: got %b expected 0", bus_a.out_ovf); end
        if (bus_a.out_valid !== 1'b0)   begin n_fails++; $display("FAIL reset_valid: got %b expected 0", bus_a.out_valid); end
        if (bus_a.frame_drops !== 8'd0) begin n_fails++; $display("FAIL reset_drops: got %0d expected 0", bus_a.frame_drops); end
        if (bus_a.busy !== 1'b0)        begin n_fails++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_basic();
        drive(1'b1, 5'd3, 1'b1);
        n_checks++;
        if (bus_a.busy !== 1'b1) begin n_fails++; $display("FAIL basic_busy_rise: got %b expected 1", bus_a.busy); end
        drive(1'b1, 5'd5, 1'b1);
        drive(1'b1, 5'd7, 1'b1);
        n_checks++;
        if (bus_a.out_valid !== 1'b0) begin n_fails++; $display("FAIL basic_early_valid: got %b expected 0", bus_a.out_valid); end
        drive(1'b1, 5'd9, 1'b1);
        n_checks += 4;
        if (bus_a.out_valid !== 1'b1) begin n_fails++; $display("FAIL basic_valid: got %b expected 1", bus_a.out_valid); end
        if (bus_a.out_sum !== 12'd24) begin n_fails++; $display("FAIL basic_sum: got %0d expected 24", bus_a.out_sum); end
        if (bus_a.out_ovf !== 1'b0)   begin n_fails++; $display("FAIL basic_ovf: got %b expected 0", bus_a.out_ovf); end
        if (bus_a.busy !== 1'b0)      begin n_fails++; $display("FAIL basic_busy_fall: got %b expected 0", bus_a.busy); end
        drive(1'b0, 5'd0, 1'b1);
        n_checks++;
        if (bus_a.out_valid !== 1'b0) begin n_fails++; $display("FAIL basic_handshake: got %b expected 0", bus_a.out_valid); end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd31, 1'b1);
            if (i < 3) begin
                drive(1'b0, 5'($urandom_range(0, 31)), 1'b1);
                drive(1'b0, 5'($urandom_range(0, 31)), 1'b1);
            end
        end
        n_checks += 4;
        if (bus_a.out_valid !== 1'b1) begin n_fails++; $display("FAIL gapped_valid: got %b expected 1", bus_a.out_valid); end
        if (bus_a.out_sum !== 12'd124) begin n_fails++; $display("FAIL gapped_sum: got %0d expected 124", bus_a.out_sum); end
        if (bus_b.out_sum !== 6'd63)  begin n_fails++; $display("FAIL gapped_sat_sum: got %0d expected 63", bus_b.out_sum); end
        if (bus_b.out_ovf !== 1'b1)   begin n_fails++; $display("FAIL gapped_sat_ovf: got %b expected 1", bus_b.out_ovf); end
        drive(1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_saturation();
        drive(1'b1, 5'd31, 1'b1);
        drive(1'b1, 5'd31, 1'b1);
        drive(1'b1, 5'd2, 1'b1);
        drive(1'b1, 5'd0, 1'b1);
        n_checks += 4;
        if (bus_b.out_sum !== 6'd63)  begin n_fails++; $display("FAIL sat_sum: got %0d expected 63", bus_b.out_sum); end
        if (bus_b.out_ovf !== 1'b1)   begin n_fails++; $display("FAIL sat_ovf: got %b expected 1", bus_b.out_ovf); end
        if (bus_a.out_sum !== 12'd64) begin n_fails++; $display("FAIL wide_sum: got %0d expected 64", bus_a.out_sum); end
        if (bus_a.out_ovf !== 1'b0)   begin n_fails++; $display("FAIL wide_ovf: got %b expected 0", bus_a.out_ovf); end
        for (int i = 0; i < 4; i++) drive(1'b1, 5'd1, 1'b1);
        n_checks += 2;
        if (bus_b.out_sum !== 6'd4) begin n_fails++; $display("FAIL sat_next_sum: got %0d expected 4", bus_b.out_sum); end
        if (bus_b.out_ovf !== 1'b0) begin n_fails++; $display("FAIL sat_next_ovf: got %b expected 0", bus_b.out_ovf); end
        drive(1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        for (int f = 0; f < 3; f++) begin
            drive(1'b1, 5'd1, 1'b0);
            drive(1'b1, 5'd1, 1'b0);
            drive(1'b1, 5'd1, 1'b0);
            drive(1'b1, 5'd2 - 5'(f == 0), 1'b0);  // later frames end in 2, so a leaked load shows
        end
        n_checks += 3;
        if (bus_a.out_valid !== 1'b1)   begin n_fails++; $display("FAIL bp_valid: got %b expected 1", bus_a.out_valid); end
        if (bus_a.out_sum !== 12'd4)    begin n_fails++; $display("FAIL bp_sum: got %0d expected 4", bus_a.out_sum); end
        if (bus_a.frame_drops !== 8'd2) begin n_fails++; $display("FAIL bp_drops: got %0d expected 2", bus_a.frame_drops); end
        drive(1'b0, 5'd0, 1'b1);
        n_checks += 2;
        if (bus_a.out_valid !== 1'b0)   begin n_fails++; $display("FAIL bp_release: got %b expected 0", bus_a.out_valid); end
        if (bus_a.frame_drops !== 8'd2) begin n_fails++; $display("FAIL bp_drops_hold: got %0d expected 2", bus_a.frame_drops); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drive(1'b1, 5'd1, 1'b0);
        drive(1'b1, 5'd2, 1'b0);
        drive(1'b1, 5'd2, 1'b0);
        drive(1'b1, 5'd2, 1'b0);
        n_checks++;
        if (bus_a.out_sum !== 12'd4) begin n_fails++; $display("FAIL b2b_hold: got %0d expected 4", bus_a.out_sum); end
        drive(1'b1, 5'd2, 1'b1);
        n_checks += 3;
        if (bus_a.out_sum !== 12'd8)    begin n_fails++; $display("FAIL b2b_sum: got %0d expected 8", bus_a.out_sum); end
        if (bus_a.out_valid !== 1'b1)   begin n_fails++; $display("FAIL b2b_valid: got %b expected 1", bus_a.out_valid); end
        if (bus_a.frame_drops !== 8'd2) begin n_fails++; $display("FAIL b2b_drops: got %0d expected 2", bus_a.frame_drops); end
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b1, 5'd10, 1'b0);
        drive(1'b1, 5'd10, 1'b0);
        rst = 1'b0;
        #1;
        n_checks += 4;
        if (bus_a.out_valid !== 1'b0)   begin n_fails++; $display("FAIL rmid_valid: got %b expected 0", bus_a.out_valid); end
        if (bus_a.out_sum !== 12'd0)    begin n_fails++; $display("FAIL rmid_sum: got %0d expected 0", bus_a.out_sum); end
        if (bus_a.frame_drops !== 8'd0) begin n_fails++; $display("FAIL rmid_drops: got %0d expected 0", bus_a.frame_drops); end
        if (bus_a.busy !== 1'b0)        begin n_fails++; $display("FAIL rmid_busy: got %b expected 0", bus_a.busy); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        drive(1'b1, 5'd1, 1'b1);
        drive(1'b1, 5'd2, 1'b1);
        drive(1'b1, 5'd3, 1'b1);
        drive(1'b1, 5'd4, 1'b1);
        n_checks += 2;
        if (bus_a.out_valid !== 1'b1) begin n_fails++; $display("FAIL rmid_next_valid: got %b expected 1", bus_a.out_valid); end
        if (bus_a.out_sum !== 12'd10) begin n_fails++; $display("FAIL rmid_next_sum: got %0d expected 10", bus_a.out_sum); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 9) < ((n < 200) ? 3 : 8)));
            n_checks += 7;
            if (bus_a.out_valid !== m_ov)
                begin n_fails++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, bus_a.out_valid, m_ov); end
            if (bus_a.busy !== m_busy)
                begin n_fails++; $display("FAIL rand_busy[%0d]: got %b expected %b", n, bus_a.busy, m_busy); end
            if (int'(bus_a.frame_drops) != m_drops)
                begin n_fails++; $display("FAIL rand_drops[%0d]: got %0d expected %0d", n, bus_a.frame_drops, m_drops); end
            if (int'(bus_a.out_sum) != m_sum_a)
                begin n_fails++; $display("FAIL rand_sum_a[%0d]: got %0d expected %0d", n, bus_a.out_sum, m_sum_a); end
            if (bus_a.out_ovf !== m_ovf_a)
                begin n_fails++; $display("FAIL rand_ovf_a[%0d]: got %b expected %b", n, bus_a.out_ovf, m_ovf_a); end
            if (int'(bus_b.out_sum) != m_sum_b)
                begin n_fails++; $display("FAIL rand_sum_b[%0d]: got %0d expected %0d", n, bus_b.out_sum, m_sum_b); end
            if (bus_b.out_ovf !== m_ovf_b)
                begin n_fails++; $display("FAIL rand_ovf_b[%0d]: got %b expected %b", n, bus_b.out_ovf, m_ovf_b); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_clear();
        bus_a.valid = 1'b0;  bus_a.c = '0;  bus_a.out_ready = 1'b0;
        bus_b.valid = 1'b0;  bus_b.c = '0;  bus_b.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
